// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2, K=4 convolutional encoder
// and the Viterbi decoder that consumes its symbol stream.
package viterbi_pkg;

  localparam int K          = 4;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int TAIL_LEN   = K - 1;

  localparam logic [K-1:0] G0_DEF = 4'b1101;
  localparam logic [K-1:0] G1_DEF = 4'b1111;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } enc_state_t;

  // XOR-reduce of the encoder window masked by a generator polynomial.
  function automatic logic parity_tap(input logic [K-1:0] win,
                                      input logic [K-1:0] gen);
    return ^(win & gen);
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder core: the K-1 bit history register plus the two generator taps.
// Code bits are combinational from the current input and the history.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_shift,
  input  logic i_b,
  output logic o_c0,
  output logic o_c1
);

  localparam int SR_W = $clog2(NUM_STATES);

  logic [SR_W-1:0] r_sr;
  logic [K-1:0]    w_win;

  // Window MSB is the current bit; r_sr[SR_W-1] is the most recent past bit.
  assign w_win = {i_b, r_sr};
  assign o_c0  = parity_tap(w_win, G0);
  assign o_c1  = parity_tap(w_win, G1);

  // Shift the history on every encoded slot; the tail flushes it back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= {i_b, r_sr[SR_W-1:1]};
    end
  end

endmodule

// File: rtl/conv_encoder_framer.sv
// Frame sequencer around the convolutional encoder core. Accepts FRAME_LEN
// data bits, appends TAIL_LEN zero bits, and registers one symbol per slot
// so the downstream decoder sees an unbroken enable for the whole frame.
module conv_encoder_framer
  import viterbi_pkg::*;
#(
  parameter int           FRAME_LEN = 1024,
  parameter logic [K-1:0] G0        = G0_DEF,
  parameter logic [K-1:0] G1        = G1_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic       out_valid,
  output logic [1:0] out_sym,
  output logic       frame_done,
  output logic       underrun,
  input  logic       clear_err
);

  // The counter is shared by the data and tail phases, so it must also be
  // able to reach TAIL_LEN-1 when FRAME_LEN is very small.
  localparam int CNT_W = $clog2((FRAME_LEN > 4) ? FRAME_LEN : 4);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(TAIL_LEN - 1);

  enc_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  sym_t             r_sym_p1;
  logic             r_vld_p1;
  logic             r_done_p1;
  logic             r_underrun;

  logic w_slot;
  logic w_b;
  logic w_c0;
  logic w_c1;

  assign w_slot = (r_state == DATA) || (r_state == TAIL);
  // Missing data is replaced by a zero bit; tail bits are always zero.
  assign w_b    = (r_state == DATA) ? (in_valid & in_bit) : 1'b0;

  conv_enc_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_shift (w_slot),
    .i_b     (w_b),
    .o_c0    (w_c0),
    .o_c1    (w_c1)
  );

  // Stage p0 -> p1: framer FSM, slot counter, symbol register and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sym_p1   <= 2'b00;
      r_vld_p1   <= 1'b0;
      r_done_p1  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_vld_p1  <= w_slot;
      r_done_p1 <= (r_state == TAIL) && (r_cnt == LAST_TAIL);
      if (w_slot) begin
        r_sym_p1 <= {w_c0, w_c1};
      end

      // A starved data slot sets the flag even if a clear arrives with it.
      if ((r_state == DATA) && !in_valid) begin
        r_underrun <= 1'b1;
      end else if (clear_err) begin
        r_underrun <= 1'b0;
      end

      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
        end
        DATA: begin
          if (r_cnt == LAST_DATA) begin
            r_state <= TAIL;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        TAIL: begin
          if (r_cnt == LAST_TAIL) begin
            r_state <= start ? DATA : IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == DATA);
  assign out_valid  = r_vld_p1;
  assign out_sym    = r_sym_p1;
  assign frame_done = r_done_p1;
  assign underrun   = r_underrun;

endmodule
